pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_pkg.sv | 26 ++
 rtl/pipe_skid_reg_sat_counter.sv | 38 +++
 rtl/pipe_skid_reg.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline package: skid-register state encoding, default payload and
// counter widths, and the state-to-occupancy mapping.
package pipe_skid_reg_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_CTRL_W = 6;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    function automatic logic [1:0] occ_of(input skid_state_e s);
        logic [1:0] occ;
        case (s)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_TWO:   occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating event counter: counts one per enabled cycle and sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register (main + skid) with flush, bubble-safe
// control output and saturating bubble/stall performance counters.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CTRL_W = DEF_CTRL_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [1:0]        occ_q, occ_d;

    logic in_xfer_s;
    logic out_xfer_s;
    logic bubble_inc_s;
    logic stall_inc_s;

    // in_ready is gated by reset so nothing is offered as accepted while held in reset.
    assign in_ready   = reset & (state_q != ST_TWO) & ~flush;
    assign out_valid  = (state_q != ST_EMPTY);
    assign in_xfer_s  = in_valid & in_ready;
    assign out_xfer_s = out_valid & out_ready;

    // Next-state and entry-update logic; flush overrides every transition.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer_s) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                    state_d     = ST_ONE;
                end else begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_xfer_s && out_xfer_s) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                    state_d     = ST_ONE;
                end else if (in_xfer_s) begin
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                    state_d     = ST_TWO;
                end else if (out_xfer_s) begin
                    state_d     = ST_EMPTY;
                end else begin
                    state_d     = ST_ONE;
                end
            end
            ST_TWO: begin
                // Skid drains into main, keeping arrival order.
                if (out_xfer_s) begin
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    state_d     = ST_ONE;
                end else begin
                    state_d     = ST_TWO;
                end
            end
            default: begin
                state_d     = ST_EMPTY;
                main_ctrl_d = {CTRL_W{1'b0}};
                skid_ctrl_d = {CTRL_W{1'b0}};
            end
        endcase
        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = {CTRL_W{1'b0}};
            skid_ctrl_d = {CTRL_W{1'b0}};
        end else begin
            state_d     = state_d;
        end
        occ_d = occ_of(state_d);
    end

    // State, occupancy and entry registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            occ_q       <= 2'd0;
            main_data_q <= {DATA_W{1'b0}};
            main_ctrl_q <= {CTRL_W{1'b0}};
            skid_data_q <= {DATA_W{1'b0}};
            skid_ctrl_q <= {CTRL_W{1'b0}};
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    // Control is masked on bubbles so no stale enable reaches the next stage.
    assign out_ctrl  = out_valid ? main_ctrl_q : {CTRL_W{1'b0}};
    assign out_data  = main_data_q;
    assign occupancy = occ_q;

    assign bubble_inc_s = ~out_valid;
    assign stall_inc_s  = out_valid & ~out_ready;

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (bubble_inc_s),
        .cnt_o (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (stall_inc_s),
        .cnt_o (stall_cnt)
    );

endmodule
